// File: rtl/remap_reg_file.sv
// Register file with a logical-to-physical map: swap any two logical regs, restore identity, debug counter.
// Latency: reads are combinational; writes, swaps and restores are visible on reads one cycle after the edge.
// Backpressure: none; every command completes in a single cycle, so the block is always ready.
module remap_reg_file #(
    parameter int W    = 8,
    parameter int NREG = 4,
    parameter int AW   = $clog2(NREG),
    parameter int CNTW = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [AW-1:0]   rd_addrA,
    input  logic [AW-1:0]   rd_addrB,
    input  logic            wr_en,
    input  logic [AW-1:0]   wr_addr,
    input  logic [W-1:0]    dat_in,
    input  logic            swap_en,
    input  logic [AW-1:0]   swap_a,
    input  logic [AW-1:0]   swap_b,
    input  logic            restore,
    output logic [W-1:0]    datA_out,
    output logic [W-1:0]    datB_out,
    output logic [AW-1:0]   phys_A,
    output logic            swapped,
    output logic [CNTW-1:0] swap_cnt
);

    logic [W-1:0]  data    [NREG];
    logic [AW-1:0] map     [NREG];
    logic [AW-1:0] map_nxt [NREG];
    logic          swap_hit;
    logic          map_nxt_ident;

    // Reads go through the current map; a write in the same cycle is not bypassed.
    assign phys_A   = map[rd_addrA];
    assign datA_out = data[map[rd_addrA]];
    assign datB_out = data[map[rd_addrB]];

    // Next map: restore beats swap, a self-swap is a no-op; also flag whether it is identity.
    always_comb begin
        swap_hit = swap_en && (swap_a != swap_b) && !restore;
        for (int i = 0; i < NREG; i++) begin
            map_nxt[i] = map[i];
        end
        if (restore) begin
            for (int i = 0; i < NREG; i++) begin
                map_nxt[i] = AW'(i);
            end
        end else if (swap_hit) begin
            map_nxt[swap_a] = map[swap_b];
            map_nxt[swap_b] = map[swap_a];
        end
        map_nxt_ident = 1'b1;
        for (int i = 0; i < NREG; i++) begin
            if (map_nxt[i] != AW'(i)) begin
                map_nxt_ident = 1'b0;
            end
        end
    end

    // State update; the write always targets the physical reg chosen by the pre-edge map.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NREG; i++) begin
                data[i] <= '0;
                map[i]  <= AW'(i);
            end
            swapped  <= 1'b0;
            swap_cnt <= '0;
        end else begin
            if (wr_en) begin
                data[map[wr_addr]] <= dat_in;
            end
            for (int i = 0; i < NREG; i++) begin
                map[i] <= map_nxt[i];
            end
            swapped <= !map_nxt_ident;
            if (restore) begin
                swap_cnt <= '0;
            end else if (swap_hit && (swap_cnt != {CNTW{1'b1}})) begin
                swap_cnt <= swap_cnt + CNTW'(1);
            end
        end
    end

endmodule
